rram_access_sequencer: RTL and testbench

Sequences single-cell RRAM read and write operations for the 16x16 array.
- Accepts row/column requests over a valid/ready handshake.
- Issues the 32-bit instruction word to instruction_decoder_RRAM.
- Times the precharge, wordline/bitline/sourceline enable, sense-amp enable and recovery phases with programmable cycle counts.
- Returns read data, or a write completion, on a one-cycle response strobe.

---
 rtl/rram_access_sequencer.sv | 171 +++++++++++++++++
 tb/tb_rram_access_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/rram_access_sequencer.sv
// Single-cell read/write sequencer for the 16x16 RRAM array: drives the decoder word and phase enables.
// Optional write-verify with bounded retries when RRAM_WRITE_VERIFY_EN is defined.
module rram_access_sequencer #(
  parameter int ADDR_W      = 4,
  parameter int PRE_CYC     = 2,
  parameter int SENSE_CYC   = 3,
  parameter int WRITE_CYC   = 4,
  parameter int RECOVER_CYC = 1,
  parameter int MAX_RETRY   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_row,
  input  logic [ADDR_W-1:0] req_col,
  input  logic              req_wdata,
  output logic [31:0]       instruction,
  output logic              pre,
  output logic              enable_wl,
  output logic              enable_bl,
  output logic              enable_sl,
  output logic              saen_csa,
  input  logic              sa_out,
  output logic              rsp_valid,
  output logic              rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int unsigned PRE_LEN     = (PRE_CYC < 1)     ? 1 : PRE_CYC;
  localparam int unsigned SENSE_LEN   = (SENSE_CYC < 1)   ? 1 : SENSE_CYC;
  localparam int unsigned WRITE_LEN   = (WRITE_CYC < 1)   ? 1 : WRITE_CYC;
  localparam int unsigned RECOVER_LEN = (RECOVER_CYC < 1) ? 1 : RECOVER_CYC;
  localparam logic [3:0]  OP_WRITE    = 4'b1000;
  localparam logic [3:0]  OP_READ     = 4'b0001;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PRE, S_SENSE, S_WRITE, S_RECOVER, S_RESP
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_load;
  logic        phase_done, accept, write_q, verifying;

  assign phase_done = (cnt == 16'd0);
  assign req_ready  = (state == S_IDLE) && !rst;

`ifdef RRAM_WRITE_VERIFY_EN
  logic [7:0] retry_cnt;
  logic       rsp_err_q, verify_ok;

  // instruction[8] still carries the requested bit while the verify read runs
  assign verify_ok = (rsp_rdata == instruction[8]);
  assign rsp_err   = rsp_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      verifying <= 1'b0;
      retry_cnt <= 8'd0;
      rsp_err_q <= 1'b0;
    end else begin
      if (accept) begin
        verifying <= 1'b0;
        retry_cnt <= 8'd0;
      end
      if (state == S_RECOVER && phase_done && write_q) begin
        if (state_nxt == S_SETUP) begin
          verifying <= 1'b1;
        end else if (state_nxt == S_WRITE) begin
          verifying <= 1'b0;
          retry_cnt <= retry_cnt + 8'd1;
        end
      end
      if (state_nxt == S_RESP) rsp_err_q <= write_q && !verify_ok;
    end
  end
`else
  assign verifying = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req_valid) begin
          state_nxt = S_SETUP;
          accept    = 1'b1;
        end
      end
      S_SETUP:   state_nxt = (write_q && !verifying) ? S_WRITE : S_PRE;
      S_PRE:     if (phase_done) state_nxt = S_SENSE;
      S_SENSE:   if (phase_done) state_nxt = S_RECOVER;
      S_WRITE:   if (phase_done) state_nxt = S_RECOVER;
      S_RECOVER: begin
        if (phase_done) begin
          state_nxt = S_RESP;
`ifdef RRAM_WRITE_VERIFY_EN
          if (write_q && !verifying)
            state_nxt = S_SETUP;
          else if (write_q && !verify_ok && retry_cnt < 8'(MAX_RETRY))
            state_nxt = S_WRITE;
`endif
        end
      end
      S_RESP:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Counter holds length-1 on entry to a timed phase and counts down to 0
  always_comb begin
    cnt_load = 16'd0;
    unique case (state_nxt)
      S_PRE:     cnt_load = 16'(PRE_LEN - 1);
      S_SENSE:   cnt_load = 16'(SENSE_LEN - 1);
      S_WRITE:   cnt_load = 16'(WRITE_LEN - 1);
      S_RECOVER: cnt_load = 16'(RECOVER_LEN - 1);
      default:   cnt_load = 16'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= 16'd0;
      write_q     <= 1'b0;
      instruction <= 32'h0;
      pre         <= 1'b0;
      enable_wl   <= 1'b0;
      enable_bl   <= 1'b0;
      enable_sl   <= 1'b0;
      saen_csa    <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) cnt <= cnt_load;
      else if (!phase_done)   cnt <= cnt - 16'd1;

      if (accept) begin
        write_q     <= req_write;
        instruction <= {(req_write ? OP_WRITE : OP_READ), 19'd0, req_wdata,
                        4'(req_row), 4'(req_col)};
      end
`ifdef RRAM_WRITE_VERIFY_EN
      if (state == S_RECOVER && state_nxt == S_SETUP) instruction[31:28] <= OP_READ;
      if (state == S_RECOVER && state_nxt == S_WRITE) instruction[31:28] <= OP_WRITE;
`endif
      if (state == S_RESP) instruction <= 32'h0;

      if (state == S_SENSE && phase_done) rsp_rdata <= sa_out;
      // Unverified writes report a zero read bit
      if (state == S_RECOVER && state_nxt == S_RESP && write_q && !verifying)
        rsp_rdata <= 1'b0;

      pre       <= (state_nxt == S_PRE);
      enable_wl <= (state_nxt == S_SENSE) || (state_nxt == S_WRITE);
      enable_bl <= (state_nxt == S_WRITE);
      enable_sl <= (state_nxt == S_WRITE);
      saen_csa  <= (state_nxt == S_SENSE);
      rsp_valid <= (state_nxt == S_RESP);
      busy      <= (state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_rram_access_sequencer.sv
// Directed bench for rram_access_sequencer with a response scoreboard.
// Covers reset, read/write phase timing, back-to-back acceptance, mid-op reset and write-verify.
module tb_rram_access_sequencer;
  localparam int PRE = 2, SEN = 3, WR = 4, REC = 1, MR = 3;
`ifdef RRAM_WRITE_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif
  localparam int RD_LAT = 1 + PRE + SEN + REC;
  localparam int WR_LAT = VERIFY ? (1 + WR + REC + 1 + PRE + SEN + REC) : (1 + WR + REC);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, req_wdata = 1'b0, sa_out = 1'b0;
  logic [3:0]  req_row = 4'd0, req_col = 4'd0;
  logic        req_ready, pre, enable_wl, enable_bl, enable_sl, saen_csa;
  logic        rsp_valid, rsp_rdata, rsp_err, busy;
  logic [31:0] instruction;

  int checks = 0;
  int errors = 0;
  logic [1:0] sb_q[$];  // {rdata, err}

  rram_access_sequencer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_row(req_row), .req_col(req_col), .req_wdata(req_wdata),
    .instruction(instruction), .pre(pre), .enable_wl(enable_wl), .enable_bl(enable_bl),
    .enable_sl(enable_sl), .saen_csa(saen_csa), .sa_out(sa_out), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request from IDLE and checks the word loaded on the accept edge
  task automatic issue(input logic w, input logic [3:0] r, input logic [3:0] c,
                       input logic wd, input logic [31:0] exp_instr);
    req_write = w; req_row = r; req_col = c; req_wdata = wd; req_valid = 1'b1;
    chk("ready_before_accept", 32'(req_ready), 32'd1);
    tick();
    chk("instr_on_accept", instruction, exp_instr);
    chk("busy_on_accept", 32'({req_ready, busy}), 32'b01);
  endtask

  task automatic run_to_rsp(input logic w, input int lat, input int exp_wr, input bit exact);
    int wr_seen = 0;
    bit done = 1'b0;
    logic [1:0] exp;
    for (int k = 1; k <= 200 && !done; k++) begin
      logic [4:0] e;
      tick();
      e = 5'b0;
      if (!w) begin
        if (k <= PRE) e = 5'b10000;
        else if (k <= PRE + SEN) e = 5'b01001;
      end else if (k <= WR) begin
        e = 5'b01110;
      end
      if (exact)
        chk("phase_outputs", 32'({pre, enable_wl, enable_bl, enable_sl, saen_csa}), 32'(e));
      chk("ready_low_while_busy", 32'({req_ready, busy}), 32'b01);
      if (enable_bl) wr_seen++;
      if (rsp_valid) begin
        done = 1'b1;
        chk("rsp_latency", 32'(k), 32'(lat));
        chk("write_cycles", 32'(wr_seen), 32'(exp_wr));
        if (sb_q.size() == 0) begin
          chk("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
          exp = sb_q.pop_front();
          chk("rsp_data_err", 32'({rsp_rdata, rsp_err}), 32'(exp));
        end
      end
    end
    if (!done) chk("rsp_timeout", 32'd0, 32'd1);
    tick();
    chk("instr_cleared", instruction, 32'h0);
    chk("idle_after_rsp", 32'({req_ready, busy, rsp_valid}), 32'b100);
  endtask

  initial begin
    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_outputs", 32'({pre, enable_wl, enable_bl, enable_sl, saen_csa,
                               rsp_valid, rsp_rdata, rsp_err, busy, req_ready}), 32'd0);
      chk("reset_instr", instruction, 32'h0);
    end
    rst = 1'b0;
    tick();
    chk("ready_after_reset", 32'({req_ready, busy}), 32'b10);

    // Read row 1 col 5, sensed 1
    sa_out = 1'b1;
    sb_q.push_back(2'b10);
    issue(1'b0, 4'd1, 4'd5, 1'b0, 32'h10000015);
    req_valid = 1'b0;
    run_to_rsp(1'b0, RD_LAT, 0, 1'b1);
    sa_out = 1'b0;
    tick();
    chk("rdata_holds", 32'(rsp_rdata), 32'd1);

    // Write row 7 col 14, wdata 1 (sense agrees so a verify pass succeeds)
    sa_out = 1'b1;
    sb_q.push_back({VERIFY, 1'b0});
    issue(1'b1, 4'd7, 4'd14, 1'b1, 32'h8000017E);
    req_valid = 1'b0;
    run_to_rsp(1'b1, WR_LAT, WR, !VERIFY);

    // Read row 15 col 0, sensed 0
    sa_out = 1'b0;
    sb_q.push_back(2'b00);
    issue(1'b0, 4'd15, 4'd0, 1'b0, 32'h100000F0);
    req_valid = 1'b0;
    run_to_rsp(1'b0, RD_LAT, 0, 1'b1);

    // Back-to-back: valid held high, second request waits through the whole first op
    sa_out = 1'b0;
    sb_q.push_back(2'b00);
    issue(1'b0, 4'd2, 4'd3, 1'b0, 32'h10000023);
    req_write = 1'b1; req_row = 4'd4; req_col = 4'd10; req_wdata = 1'b0;
    sb_q.push_back(2'b00);
    run_to_rsp(1'b0, RD_LAT, 0, 1'b1);
    issue(1'b1, 4'd4, 4'd10, 1'b0, 32'h8000004A);
    req_valid = 1'b0;
    run_to_rsp(1'b1, WR_LAT, WR, !VERIFY);

    // Reset during the second SENSE cycle
    sa_out = 1'b1;
    issue(1'b0, 4'd6, 4'd6, 1'b0, 32'h10000066);
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("in_second_sense", 32'({enable_wl, saen_csa}), 32'b11);
    rst = 1'b1;
    tick();
    chk("midop_reset_outputs", 32'({pre, enable_wl, enable_bl, enable_sl, saen_csa,
                                    rsp_valid, busy, req_ready}), 32'd0);
    chk("midop_reset_instr", instruction, 32'h0);
    rst = 1'b0;
    #1;
    chk("ready_after_midop_reset", 32'(req_ready), 32'd1);
    tick();
    chk("no_rsp_after_abort", 32'({rsp_valid, busy}), 32'd0);
    sb_q.push_back(2'b10);
    issue(1'b0, 4'd6, 4'd6, 1'b0, 32'h10000066);
    req_valid = 1'b0;
    run_to_rsp(1'b0, RD_LAT, 0, 1'b1);

`ifdef RRAM_WRITE_VERIFY_EN
    // sa_out stuck at 0 against wdata 1: every retry fails
    sa_out = 1'b0;
    sb_q.push_back(2'b01);
    issue(1'b1, 4'd3, 4'd9, 1'b1, 32'h80000139);
    req_valid = 1'b0;
    run_to_rsp(1'b1, 1 + (MR + 1) * (WR + REC + 1 + PRE + SEN + REC), (MR + 1) * WR, 1'b0);
    // Same write, sense agrees on the first verify
    sa_out = 1'b1;
    sb_q.push_back(2'b10);
    issue(1'b1, 4'd3, 4'd9, 1'b1, 32'h80000139);
    req_valid = 1'b0;
    run_to_rsp(1'b1, 13, WR, 1'b0);
`endif

    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
